// File: rtl/caliptra_fpga_apb_initiator.sv
// rtl/caliptra_fpga_apb_initiator.sv - valid/ready to APB initiator, optional ACCESS timeout (CALIPTRA_FPGA_APB_INIT_TIMEOUT_EN)
module caliptra_fpga_apb_initiator #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int USER_W         = 32,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              core_clk,
    input  logic              core_rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [USER_W-1:0] req_user,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [7:0]        err_count,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    output logic [USER_W-1:0] PAUSER,
    output logic [2:0]        PPROT,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_ACCESS, ST_RESP} state_t;

    state_t            r_state,       w_state_nxt;
    logic              r_req_ready,   w_req_ready_nxt;
    logic              r_psel,        w_psel_nxt;
    logic              r_penable,     w_penable_nxt;
    logic              r_pwrite,      w_pwrite_nxt;
    logic [ADDR_W-1:0] r_paddr,       w_paddr_nxt;
    logic [DATA_W-1:0] r_pwdata,      w_pwdata_nxt;
    logic [USER_W-1:0] r_pauser,      w_pauser_nxt;
    logic              r_rsp_valid,   w_rsp_valid_nxt;
    logic [DATA_W-1:0] r_rsp_rdata,   w_rsp_rdata_nxt;
    logic              r_rsp_err,     w_rsp_err_nxt;
    logic              r_rsp_timeout, w_rsp_timeout_nxt;
    logic [7:0]        r_err_count,   w_err_count_nxt;
    logic [7:0]        w_err_count_inc;

    assign w_err_count_inc = (r_err_count == 8'hFF) ? r_err_count : r_err_count + 8'd1;

`ifdef CALIPTRA_FPGA_APB_INIT_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    logic [CNT_W-1:0] r_to_cnt, w_to_cnt_nxt;
`endif

    always_comb begin
        w_state_nxt       = r_state;
        w_req_ready_nxt   = r_req_ready;
        w_psel_nxt        = r_psel;
        w_penable_nxt     = r_penable;
        w_pwrite_nxt      = r_pwrite;
        w_paddr_nxt       = r_paddr;
        w_pwdata_nxt      = r_pwdata;
        w_pauser_nxt      = r_pauser;
        w_rsp_valid_nxt   = r_rsp_valid;
        w_rsp_rdata_nxt   = r_rsp_rdata;
        w_rsp_err_nxt     = r_rsp_err;
        w_rsp_timeout_nxt = r_rsp_timeout;
        w_err_count_nxt   = r_err_count;
`ifdef CALIPTRA_FPGA_APB_INIT_TIMEOUT_EN
        w_to_cnt_nxt      = r_to_cnt;
`endif
        case (r_state)
            ST_IDLE: begin
                // req_ready rises one cycle after reset, then the request is taken only once it is visible
                w_req_ready_nxt = 1'b1;
                if (req_valid && r_req_ready) begin
                    w_pwrite_nxt    = req_write;
                    w_paddr_nxt     = req_addr;
                    w_pwdata_nxt    = req_wdata;
                    w_pauser_nxt    = req_user;
                    w_req_ready_nxt = 1'b0;
                    w_psel_nxt      = 1'b1;
                    w_penable_nxt   = 1'b0;
                    w_state_nxt     = ST_SETUP;
`ifdef CALIPTRA_FPGA_APB_INIT_TIMEOUT_EN
                    w_to_cnt_nxt    = '0;
`endif
                end
            end
            ST_SETUP: begin
                w_penable_nxt = 1'b1;
                w_state_nxt   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (PREADY) begin
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_rdata_nxt   = r_pwrite ? '0 : PRDATA;
                    w_rsp_err_nxt     = PSLVERR;
                    w_rsp_timeout_nxt = 1'b0;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = ST_RESP;
                    if (PSLVERR) w_err_count_nxt = w_err_count_inc;
                end
`ifdef CALIPTRA_FPGA_APB_INIT_TIMEOUT_EN
                else if (r_to_cnt == CNT_LAST) begin
                    w_psel_nxt        = 1'b0;
                    w_penable_nxt     = 1'b0;
                    w_rsp_rdata_nxt   = '0;
                    w_rsp_err_nxt     = 1'b1;
                    w_rsp_timeout_nxt = 1'b1;
                    w_rsp_valid_nxt   = 1'b1;
                    w_state_nxt       = ST_RESP;
                    w_err_count_nxt   = w_err_count_inc;
                end else begin
                    w_to_cnt_nxt = r_to_cnt + 1'b1;
                end
`endif
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    w_rsp_valid_nxt = 1'b0;
                    w_req_ready_nxt = 1'b1;
                    w_state_nxt     = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) begin
            r_state       <= ST_IDLE;
            r_req_ready   <= 1'b0;
            r_psel        <= 1'b0;
            r_penable     <= 1'b0;
            r_pwrite      <= 1'b0;
            r_paddr       <= '0;
            r_pwdata      <= '0;
            r_pauser      <= '0;
            r_rsp_valid   <= 1'b0;
            r_rsp_rdata   <= '0;
            r_rsp_err     <= 1'b0;
            r_rsp_timeout <= 1'b0;
            r_err_count   <= 8'h00;
        end else begin
            r_state       <= w_state_nxt;
            r_req_ready   <= w_req_ready_nxt;
            r_psel        <= w_psel_nxt;
            r_penable     <= w_penable_nxt;
            r_pwrite      <= w_pwrite_nxt;
            r_paddr       <= w_paddr_nxt;
            r_pwdata      <= w_pwdata_nxt;
            r_pauser      <= w_pauser_nxt;
            r_rsp_valid   <= w_rsp_valid_nxt;
            r_rsp_rdata   <= w_rsp_rdata_nxt;
            r_rsp_err     <= w_rsp_err_nxt;
            r_rsp_timeout <= w_rsp_timeout_nxt;
            r_err_count   <= w_err_count_nxt;
        end
    end

`ifdef CALIPTRA_FPGA_APB_INIT_TIMEOUT_EN
    always_ff @(posedge core_clk or posedge core_rst) begin
        if (core_rst) r_to_cnt <= '0;
        else          r_to_cnt <= w_to_cnt_nxt;
    end
    assign rsp_timeout = r_rsp_timeout;
`else
    assign rsp_timeout = 1'b0;
`endif

    assign req_ready = r_req_ready;
    assign rsp_valid = r_rsp_valid;
    assign rsp_rdata = r_rsp_rdata;
    assign rsp_err   = r_rsp_err;
    assign err_count = r_err_count;
    assign PADDR     = r_paddr;
    assign PSEL      = r_psel;
    assign PENABLE   = r_penable;
    assign PWRITE    = r_pwrite;
    assign PWDATA    = r_pwdata;
    assign PAUSER    = r_pauser;
    assign PPROT     = 3'b000;

endmodule

// File: tb/tb_caliptra_fpga_apb_initiator.sv
// tb/tb_caliptra_fpga_apb_initiator.sv - randomized self-checking bench for caliptra_fpga_apb_initiator
module tb_caliptra_fpga_apb_initiator;

    localparam int TO = 4;

    logic        core_clk, core_rst;
    logic        req_valid, req_ready, req_write;
    logic [31:0] req_addr, req_wdata, req_user;
    logic        rsp_valid, rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err, rsp_timeout;
    logic [7:0]  err_count;
    logic [31:0] PADDR, PWDATA, PAUSER, PRDATA;
    logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
    logic [2:0]  PPROT;

    int n_tests, n_fail, model_cnt;

    caliptra_fpga_apb_initiator #(
        .ADDR_W(32), .DATA_W(32), .USER_W(32), .TIMEOUT_CYCLES(TO)
    ) dut (
        .core_clk(core_clk), .core_rst(core_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_user(req_user),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .err_count(err_count),
        .PADDR(PADDR), .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE),
        .PWDATA(PWDATA), .PAUSER(PAUSER), .PPROT(PPROT),
        .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
    );

    initial core_clk = 1'b0;
    always #5 core_clk = ~core_clk;

    // One full transfer; every cycle is compared against what the APB rules demand for these arguments.
    task automatic do_xfer(input logic wr, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [31:0] user, input int waits, input logic [31:0] rdata,
                           input logic slverr, input int hold, input bit expect_to, input string tag);
        int g;
        int n_acc;
        logic exp_err;
        logic [31:0] exp_rd;
        g = 0;
        while (req_ready !== 1'b1 && g < 20) begin
            @(negedge core_clk);
            g++;
        end
        n_tests++;
        if (req_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL %s idle_ready: got %b want 1", tag, req_ready);
        end
        req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata; req_user = user;
        @(negedge core_clk);
        req_valid = 1'($urandom); req_write = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom; req_user = $urandom;
        n_tests++;
        if ({PSEL, PENABLE, req_ready, rsp_valid} !== 4'b1000 || PADDR !== addr || PWRITE !== wr ||
            PWDATA !== wdata || PAUSER !== user || PPROT !== 3'b000) begin
            n_fail++;
            $display("FAIL %s setup: sel/en/rdy/vld=%b%b%b%b addr=%h wr=%b wd=%h user=%h want 1000 %h %b %h %h",
                     tag, PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWRITE, PWDATA, PAUSER, addr, wr, wdata, user);
        end
        n_acc = expect_to ? TO : waits + 1;
        for (int i = 0; i < n_acc; i++) begin
            @(negedge core_clk);
            PREADY  = !expect_to && (i == waits);
            PRDATA  = PREADY ? rdata : $urandom;
            PSLVERR = PREADY ? slverr : 1'($urandom);
            n_tests++;
            if ({PSEL, PENABLE, req_ready, rsp_valid} !== 4'b1100 || PADDR !== addr || PWRITE !== wr ||
                PWDATA !== wdata || PAUSER !== user) begin
                n_fail++;
                $display("FAIL %s access%0d: sel/en/rdy/vld=%b%b%b%b addr=%h wd=%h want 1100 %h %h",
                         tag, i, PSEL, PENABLE, req_ready, rsp_valid, PADDR, PWDATA, addr, wdata);
            end
        end
        @(negedge core_clk);
        PREADY = 1'b0; PRDATA = $urandom; PSLVERR = 1'($urandom);
        exp_err = expect_to | slverr;
        exp_rd  = (wr | expect_to) ? 32'h0 : rdata;
        if (exp_err && model_cnt < 255) model_cnt++;
        n_tests++;
        if ({PSEL, PENABLE, req_ready, rsp_valid} !== 4'b0001 || rsp_rdata !== exp_rd || rsp_err !== exp_err ||
            rsp_timeout !== expect_to || err_count !== 8'(model_cnt) || PADDR !== addr || PWDATA !== wdata) begin
            n_fail++;
            $display("FAIL %s resp: sel/en/rdy/vld=%b%b%b%b rd=%h err=%b to=%b cnt=%0d want 0001 %h %b %b %0d",
                     tag, PSEL, PENABLE, req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count,
                     exp_rd, exp_err, expect_to, model_cnt);
        end
        for (int i = 0; i < hold; i++) begin
            rsp_ready = 1'b0;
            @(negedge core_clk);
            PRDATA = $urandom; PSLVERR = 1'($urandom); PREADY = 1'($urandom);
            n_tests++;
            if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_rdata !== exp_rd || rsp_err !== exp_err) begin
                n_fail++;
                $display("FAIL %s hold%0d: vld=%b rdy=%b rd=%h err=%b want 1 0 %h %b",
                         tag, i, rsp_valid, req_ready, rsp_rdata, rsp_err, exp_rd, exp_err);
            end
        end
        rsp_ready = 1'b1; req_valid = 1'b0; PREADY = 1'b0;
        @(negedge core_clk);
        rsp_ready = 1'b0;
        n_tests++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1 || PSEL !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done: vld=%b rdy=%b sel=%b want 0 1 0", tag, rsp_valid, req_ready, PSEL);
        end
    endtask

    task automatic test_reset();
        core_rst = 1'b1;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0; req_user = '0;
        rsp_ready = 1'b0; PRDATA = '0; PREADY = 1'b0; PSLVERR = 1'b0;
        model_cnt = 0;
        repeat (3) begin
            @(negedge core_clk);
            PREADY = 1'($urandom); PRDATA = $urandom; req_valid = 1'($urandom);
            n_tests++;
            if ({req_ready, rsp_valid, rsp_rdata, rsp_err, rsp_timeout, err_count, PADDR, PSEL, PENABLE,
                 PWRITE, PWDATA, PAUSER, PPROT} !== '0) begin
                n_fail++;
                $display("FAIL reset_outputs: rdy=%b vld=%b sel=%b en=%b cnt=%0d addr=%h want all 0",
                         req_ready, rsp_valid, PSEL, PENABLE, err_count, PADDR);
            end
        end
        req_valid = 1'b0; PREADY = 1'b0;
        core_rst = 1'b0;
        #1;
        n_tests++;
        if (req_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 0", req_ready);
        end
        @(negedge core_clk);
        n_tests++;
        if (req_ready !== 1'b1 || PSEL !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_idle: rdy=%b sel=%b want 1 0", req_ready, PSEL);
        end
    endtask

    task automatic test_write();
        do_xfer(1'b1, 32'h3000_0000, 32'hA5A5_5A5A, 32'hFFFF_FFFF, 0, 32'hDEAD_BEEF, 1'b0, 0, 1'b0, "write0");
    endtask

    task automatic test_read_wait();
        do_xfer(1'b0, 32'h3003_0000, 32'h0, 32'h0000_0001, 5, 32'h1234_5678, 1'b0, 3, 1'b0, "read_wait");
    endtask

    task automatic test_slverr();
        do_xfer(1'b0, 32'h3003_0004, 32'h0, 32'h2, 0, 32'hCAFE_F00D, 1'b1, 1, 1'b0, "slverr_first");
        for (int k = 1; k < 300; k++)
            do_xfer(1'($urandom), $urandom, $urandom, $urandom, 0, $urandom, 1'b1, 0, 1'b0, "slverr_sat");
        n_tests++;
        if (err_count !== 8'hFF) begin
            n_fail++;
            $display("FAIL err_saturate: got %h want ff", err_count);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 40; k++)
            do_xfer(1'($urandom), $urandom, $urandom, $urandom, int'($urandom_range(0, TO - 1)),
                    $urandom, 1'($urandom), int'($urandom_range(0, 3)), 1'b0, "random");
    endtask

    task automatic test_timeout();
`ifdef CALIPTRA_FPGA_APB_INIT_TIMEOUT_EN
        do_xfer(1'b0, 32'h3000_0010, 32'h0, 32'h5, 0, 32'h0, 1'b0, 1, 1'b1, "timeout_abort");
        do_xfer(1'b0, 32'h3000_0014, 32'h0, 32'h6, TO - 1, 32'h8765_4321, 1'b0, 0, 1'b0, "timeout_ready_last");
        do_xfer(1'b1, 32'h3000_0018, 32'h77, 32'h7, 0, 32'h0, 1'b0, 0, 1'b1, "timeout_write");
`else
        do_xfer(1'b0, 32'h3000_0010, 32'h0, 32'h5, 20, 32'h0BAD_F00D, 1'b0, 0, 1'b0, "long_stall");
`endif
    endtask

    task automatic test_reset_mid();
        req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h3000_0100; req_user = 32'h9;
        @(negedge core_clk);
        req_valid = 1'b0;
        @(negedge core_clk);
        PREADY = 1'b0;
        #2 core_rst = 1'b1;
        #1;
        model_cnt = 0;
        n_tests++;
        if (PSEL !== 1'b0 || PENABLE !== 1'b0 || rsp_valid !== 1'b0 || err_count !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_mid_drop: sel=%b en=%b vld=%b cnt=%0d want 0 0 0 0", PSEL, PENABLE, rsp_valid, err_count);
        end
        @(negedge core_clk);
        core_rst = 1'b0; PREADY = 1'b1; PRDATA = $urandom;
        repeat (3) begin
            @(negedge core_clk);
            n_tests++;
            if (rsp_valid !== 1'b0 || PSEL !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_no_rsp: vld=%b sel=%b want 0 0", rsp_valid, PSEL);
            end
        end
        PREADY = 1'b0;
        do_xfer(1'b0, 32'h3000_0200, 32'h0, 32'hA, 1, 32'h5555_AAAA, 1'b0, 0, 1'b0, "after_reset");
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_write();
        test_read_wait();
        test_slverr();
        test_random();
        test_timeout();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
